// File: rtl/loop_stack.sv
// Loop stack: LIFO of program-counter values for bracket loops.
// q always presents the registered top entry, so a loop-back load needs no read bubble.
module loop_stack #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] d,
    output logic [ADDR_WIDTH-1:0] q,
    output logic [DEPTH_LOG2:0]   depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                    ENTRIES   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   MAX_DEPTH = ENTRIES[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   ONE       = 1;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE   = 1;

    logic [ADDR_WIDTH-1:0] mem [ENTRIES];
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] top_idx;
    logic [DEPTH_LOG2-1:0] below_idx;

    // Indices wrap modulo ENTRIES, which is exactly right when depth == ENTRIES.
    assign wr_idx    = depth[DEPTH_LOG2-1:0];
    assign top_idx   = wr_idx - IDX_ONE;
    assign below_idx = top_idx - IDX_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            depth     <= '0;
            q         <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (ce) begin
            if (push && pop && !empty) begin
                mem[top_idx] <= d;
                q            <= d;
            end else if (push) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    mem[wr_idx] <= d;
                    depth       <= depth + ONE;
                    q           <= d;
                    empty       <= 1'b0;
                    full        <= (depth == MAX_DEPTH - ONE);
                end
            end else if (pop) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    // empty/full are kept as flops so they never glitch off a depth decode.
                    depth <= depth - ONE;
                    full  <= 1'b0;
                    if (depth == ONE) begin
                        q     <= '0;
                        empty <= 1'b1;
                    end else begin
                        q <= mem[below_idx];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_loop_stack.sv
// Self-checking bench for loop_stack: directed scenarios plus random traffic,
// all compared against a queue-based LIFO model.
module tb_loop_stack;

    logic       clk = 1'b0;
    logic       reset, ce, push, pop;
    logic [7:0] d;
    logic [7:0] q;
    logic [4:0] depth;
    logic       empty, full, overflow, underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] model_stack[$];
    logic       model_ovf = 1'b0;
    logic       model_unf = 1'b0;

    loop_stack #(.ADDR_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .ce(ce), .push(push), .pop(pop), .d(d),
        .q(q), .depth(depth), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // LIFO rules applied to a plain queue: replace-top, push, pop, sticky errors.
    task automatic modelStep(input logic r, input logic c, input logic p, input logic o, input logic [7:0] dv);
        if (r) begin
            model_stack.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else if (c) begin
            if (p && o && model_stack.size() > 0) begin
                model_stack[model_stack.size()-1] = dv;
            end else if (p) begin
                if (model_stack.size() == 16) model_ovf = 1'b1;
                else model_stack.push_back(dv);
            end else if (o) begin
                if (model_stack.size() == 0) model_unf = 1'b1;
                else void'(model_stack.pop_back());
            end
        end
    endtask

    task automatic checkModel();
        int         n;
        logic [7:0] exp_q;
        n     = model_stack.size();
        exp_q = (n > 0) ? model_stack[n-1] : 8'h00;
        checkOutput("q", q, exp_q);
        checkOutput("depth", depth, n);
        checkOutput("empty", empty, n == 0);
        checkOutput("full", full, n == 16);
        checkOutput("overflow", overflow, model_ovf);
        checkOutput("underflow", underflow, model_unf);
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic p, input logic o, input logic [7:0] dv);
        reset = r; ce = c; push = p; pop = o; d = dv;
        @(posedge clk);
        modelStep(r, c, p, o, dv);
        #1;
        checkModel();
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; push = 1'b0; pop = 1'b0; d = 8'h00;

        // Reset then idle
        applyStimulus(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("t1_depth", depth, 0);
        checkOutput("t1_empty", empty, 1);
        checkOutput("t1_full", full, 0);
        checkOutput("t1_q", q, 0);
        checkOutput("t1_flags", {overflow, underflow}, 0);

        // Basic push/pop
        applyStimulus(0, 1, 1, 0, 8'h10);
        applyStimulus(0, 1, 1, 0, 8'h20);
        applyStimulus(0, 1, 1, 0, 8'h30);
        checkOutput("t2_q", q, 8'h30);
        checkOutput("t2_depth", depth, 3);
        applyStimulus(0, 1, 0, 1, 8'h00);
        checkOutput("t2_pop_q", q, 8'h20);
        checkOutput("t2_pop_depth", depth, 2);
        applyStimulus(0, 1, 0, 1, 8'h00);
        applyStimulus(0, 1, 0, 1, 8'h00);
        checkOutput("t2_empty_q", q, 0);
        checkOutput("t2_empty", empty, 1);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, 0, 8'(i));
        applyStimulus(0, 1, 1, 0, 8'hAA);
        checkOutput("t3_full", full, 1);
        checkOutput("t3_depth", depth, 16);
        checkOutput("t3_q", q, 8'h0F);
        checkOutput("t3_ovf", overflow, 1);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(0, 1, 0, 1, 8'h00);
            checkOutput("t3_drain_q", q, (k < 16) ? 15 - k : 0);
        end
        checkOutput("t3_drained", empty, 1);

        // Underflow is sticky
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 1, 8'h00);
        checkOutput("t4_unf", underflow, 1);
        checkOutput("t4_depth", depth, 0);
        applyStimulus(0, 1, 1, 0, 8'h05);
        checkOutput("t4_q", q, 8'h05);
        checkOutput("t4_unf_sticky", underflow, 1);

        // Replace top, and push+pop on an empty stack acts as push
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h11);
        applyStimulus(0, 1, 1, 1, 8'h22);
        checkOutput("t5_q", q, 8'h22);
        checkOutput("t5_depth", depth, 1);
        applyStimulus(0, 1, 0, 1, 8'h00);
        applyStimulus(0, 1, 1, 1, 8'h33);
        checkOutput("t5_pp_q", q, 8'h33);
        checkOutput("t5_pp_depth", depth, 1);
        checkOutput("t5_pp_unf", underflow, 0);

        // ce gating and reset priority
        applyStimulus(0, 0, 1, 0, 8'h40);
        checkOutput("t6_ce_q", q, 8'h33);
        checkOutput("t6_ce_depth", depth, 1);
        applyStimulus(1, 1, 1, 0, 8'h41);
        checkOutput("t6_rst_depth", depth, 0);
        checkOutput("t6_rst_q", q, 0);

        // Random traffic: push-heavy, pop-heavy, then balanced phases
        for (int phase = 0; phase < 3; phase++) begin
            for (int i = 0; i < 200; i++) begin
                int          push_pct;
                int          pop_pct;
                logic        r, c, p, o;
                push_pct = (phase == 0) ? 70 : (phase == 1) ? 25 : 50;
                pop_pct  = (phase == 0) ? 25 : (phase == 1) ? 70 : 50;
                r = ($urandom_range(0, 149) == 0);
                c = ($urandom_range(0, 99) < 85);
                p = ($urandom_range(0, 99) < push_pct);
                o = ($urandom_range(0, 99) < pop_pct);
                applyStimulus(r, c, p, o, 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
